fse_fir: RTL and testbench
==========================

FSE_FIR -- requirements
Module: fse_fir

Interface
REQ-001 Parameters SHALL be:
- NBx, default 8, bits of input x.
- NBFx, default 5, fractional bits of x.
- NBy, default 8, bits of output y.
- NBFy, default 5, fractional bits of y.
- Nw, default 9, number of taps.
- NBw, default 7, bits per coefficient.
- NBFw, default 5, fractional bits per coefficient.

REQ-002 Ports SHALL be:
- clkA  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_valid  in  1  input strobe; x is accepted on an edge where i_valid=1. Input is at T/2 (two samples per symbol).
- x  in  NBx  signed input sample.
- coeff  in  Nw*NBw  signed coefficients from the LMS stage; tap k occupies bits [NBw*(k+1)-1 -: NBw].
- freeze  in  1  1 = hold the coefficient bank.
- y  out  NBy  signed, saturated filter output at symbol rate.
- y_valid  out  1  one-cycle strobe marking a new y.
- d  out  1  slicer decision: 1 means +1, 0 means -1.
- sat_flag  out  1  y was saturated; qualified by y_valid.

Function
REQ-003 The delay line x_r[0..Nw-1] SHALL shift on each accept: x_r[0]<=x, x_r[k]<=x_r[k-1]. It SHALL hold when i_valid=0.
REQ-004 A phase bit SHALL toggle on each accept. An accept with phase=1 (before the toggle) is a "decimation accept" at edge N.
REQ-005 On a decimation accept with freeze=0, the coefficient bank c_r[k] SHALL load from coeff at edge N. Otherwise c_r holds.
REQ-006 Edge N+1: SHALL register the Nw products x_r[k]*c_r[k], full precision (NBx+NBw bits, NBFx+NBFw fractional).
REQ-007 Edge N+2: SHALL register the full-precision sum of the products, with NBx+NBw+ceil(log2(Nw)) bits so that no internal overflow is possible.
REQ-008 Edge N+3: SHALL register y, d and sat_flag, and pulse y_valid high for exactly one cycle. Latency is 3 cycles.
REQ-009 Output quantisation SHALL truncate (floor) the sum by (NBFx+NBFw-NBFy) LSBs, then saturate to NBy bits: above 2^(NBy-1)-1 gives 2^(NBy-1)-1, below -2^(NBy-1) gives -2^(NBy-1).
REQ-010 sat_flag SHALL be 1 exactly when REQ-009 clipped the value.
REQ-011 d SHALL equal ~y[NBy-1], so y>=0 gives d=1. It SHALL update only with y_valid.
REQ-012 The pipeline SHALL be fully pipelined. i_valid=1 every cycle SHALL be sustained, giving y_valid every second cycle with no stall. Gaps in i_valid SHALL not corrupt in-flight results.
REQ-013 y, d and sat_flag SHALL hold their last values between y_valid strobes.
REQ-014 The coefficient bank used for a result SHALL be the one loaded at that result's edge N. coeff changes at any other time SHALL have no effect on that result.
REQ-015 freeze SHALL affect only the coefficient bank. The data path and decimation SHALL keep running.

Reset
REQ-016 While reset=1 at an edge, the following SHALL be cleared:
- x_r, product and sum registers set to 0;
- phase set to 0;
- all pipeline valid flags cleared;
- y=0, y_valid=0, d=0, sat_flag=0;
- c_r set to 0 except centre tap c_r[Nw/2] = 1.0 (7'b0100000 at defaults).
REQ-017 Reset SHALL be accepted in any pipeline state. Results in flight SHALL be discarded, with no y_valid after reset release until two fresh accepts +3 cycles.
REQ-018 i_valid coincident with reset SHALL be ignored.

Verification
REQ-019 Centre-tap identity: coeff tap 4 = 32, others 0; x=32 continuous for 12 accepts -> after the pipeline fills, y=32, d=1, sat_flag=0, y_valid every second cycle.
REQ-020 Saturation: all taps = 63; x=127 for 10 accepts -> y=127, sat_flag=1, d=1. Then x=-128 for 10 accepts -> y=-128, sat_flag=1, d=0.
REQ-021 Cadence: i_valid every cycle -> first y_valid 3 cycles after the second accept. Then i_valid 1-in-3 -> y_valid every 6 cycles, and the y sequence matches the continuous run for the same x.
REQ-022 Freeze: freeze=1, then change coeff from identity to all-zero -> y keeps the identity result. freeze=0 -> y=0 from the result of the next decimation accept onward.
REQ-023 Mid-stream reset: reset=1 for 1 cycle between a decimation accept and its y_valid -> that y_valid is suppressed and y=0. The next y_valid comes 3 cycles after the second post-reset accept.

Source files
------------

// File: rtl/fse_fir.sv
// Fractionally spaced (T/2) FIR equaliser: decimate-by-2 output with a
// 3-cycle multiply / sum / quantise pipeline and a freezable coefficient bank.
module fse_fir #(
  parameter int NBx  = 8,
  parameter int NBFx = 5,
  parameter int NBy  = 8,
  parameter int NBFy = 5,
  parameter int Nw   = 9,
  parameter int NBw  = 7,
  parameter int NBFw = 5
) (
  input  logic                  clkA,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic signed [NBx-1:0] x,
  input  logic [Nw*NBw-1:0]     coeff,
  input  logic                  freeze,
  output logic signed [NBy-1:0] y,
  output logic                  y_valid,
  output logic                  d,
  output logic                  sat_flag
);

  localparam int NBP = NBx + NBw;
  localparam int NBS = NBP + $clog2(Nw);
  localparam int SH  = NBFx + NBFw - NBFy;

  localparam logic signed [NBw-1:0] CENTRE = NBw'(1 << NBFw);
  localparam logic signed [NBS-1:0] YMAX   = NBS'((2 ** (NBy - 1)) - 1);
  localparam logic signed [NBS-1:0] YMIN   = NBS'(-(2 ** (NBy - 1)));

  logic signed [NBw-1:0] coeff_w [Nw];
  logic signed [NBx-1:0] x_r_q   [Nw];
  logic signed [NBw-1:0] c_r_q   [Nw];
  logic signed [NBP-1:0] prod_q  [Nw];
  logic signed [NBS-1:0] sum_q, sum_d, q_full;
  logic signed [NBy-1:0] y_q, y_d;
  logic                  sat_d;
  logic                  phase_q, dec_q, pv_q, sv_q;
  logic                  y_valid_q, d_q, sat_q;

  genvar gi;
  generate
    for (gi = 0; gi < Nw; gi++) begin : g_unpack
      assign coeff_w[gi] = coeff[NBw*(gi+1)-1 -: NBw];
    end
  endgenerate

  // Products are sign-extended to full width before multiplying so the
  // product is exact in NBP bits.
  always_ff @(posedge clkA) begin
    if (reset) begin
      for (int k = 0; k < Nw; k++) begin
        x_r_q[k]  <= '0;
        c_r_q[k]  <= (k == Nw / 2) ? CENTRE : '0;
        prod_q[k] <= '0;
      end
      sum_q     <= '0;
      phase_q   <= 1'b0;
      dec_q     <= 1'b0;
      pv_q      <= 1'b0;
      sv_q      <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      d_q       <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      if (i_valid) begin
        x_r_q[0] <= x;
        for (int k = 1; k < Nw; k++) x_r_q[k] <= x_r_q[k-1];
        phase_q <= ~phase_q;
        if (phase_q && !freeze) begin
          for (int k = 0; k < Nw; k++) c_r_q[k] <= coeff_w[k];
        end
      end
      dec_q <= i_valid & phase_q;
      if (dec_q) begin
        for (int k = 0; k < Nw; k++)
          prod_q[k] <= $signed({{NBw{x_r_q[k][NBx-1]}}, x_r_q[k]}) *
                       $signed({{NBx{c_r_q[k][NBw-1]}}, c_r_q[k]});
      end
      pv_q <= dec_q;
      if (pv_q) sum_q <= sum_d;
      sv_q      <= pv_q;
      y_valid_q <= sv_q;
      if (sv_q) begin
        y_q   <= y_d;
        d_q   <= ~y_d[NBy-1];
        sat_q <= sat_d;
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < Nw; k++) sum_d = sum_d + NBS'(prod_q[k]);
  end

  // Arithmetic shift floors the value; saturation then clips to NBy bits.
  always_comb begin
    q_full = sum_q >>> SH;
    y_d    = q_full[NBy-1:0];
    sat_d  = 1'b0;
    if (q_full > YMAX) begin
      y_d   = YMAX[NBy-1:0];
      sat_d = 1'b1;
    end else if (q_full < YMIN) begin
      y_d   = YMIN[NBy-1:0];
      sat_d = 1'b1;
    end
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign d        = d_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_fse_fir.sv
// Bench for fse_fir: each scenario task drives stimulus and compares the DUT
// against a sample-history / coefficient-bank model with a result queue.
module tb_fse_fir;
  localparam int NW = 9;

  logic              clkA = 1'b0;
  logic              reset, i_valid, freeze;
  logic signed [7:0] x;
  logic [62:0]       coeff;
  logic signed [7:0] y;
  logic              y_valid, d, sat_flag;

  fse_fir dut (
    .clkA(clkA), .reset(reset), .i_valid(i_valid), .x(x), .coeff(coeff),
    .freeze(freeze), .y(y), .y_valid(y_valid), .d(d), .sat_flag(sat_flag)
  );

  always #5 clkA = ~clkA;

  typedef struct { int due; int yv; bit s; } res_t;
  int   hist [NW];
  int   bank [NW];
  bit   phase;
  res_t pend [$];
  int   cyc;
  logic              exp_v, exp_d, exp_s;
  logic signed [7:0] exp_y;
  int   total, bad;

  function automatic logic [62:0] pack_uniform(int v);
    logic [62:0] p;
    for (int k = 0; k < NW; k++) p[7*k +: 7] = 7'(v);
    return p;
  endfunction

  function automatic logic [62:0] pack_identity();
    logic [62:0] p;
    p = '0;
    p[7*4 +: 7] = 7'd32;
    return p;
  endfunction

  // Apply one clock of stimulus and advance the reference model; results
  // due at this edge appear in exp_* (outputs otherwise hold).
  task automatic tick(input bit rst, input bit iv, input int xv, input bit frz,
                      input logic [62:0] cf);
    int   acc, q;
    res_t r;
    reset = rst; i_valid = iv; x = 8'(xv); freeze = frz; coeff = cf;
    @(posedge clkA);
    cyc++;
    if (rst) begin
      for (int k = 0; k < NW; k++) begin
        hist[k] = 0;
        bank[k] = (k == NW / 2) ? 32 : 0;
      end
      phase = 0;
      pend.delete();
      exp_y = 0; exp_d = 0; exp_s = 0;
    end else if (iv) begin
      for (int k = NW - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = xv;
      if (phase) begin
        if (!frz) for (int k = 0; k < NW; k++) bank[k] = $signed(cf[7*k +: 7]);
        acc = 0;
        for (int k = 0; k < NW; k++) acc += hist[k] * bank[k];
        q = acc >>> 5;
        r.s  = (q > 127) || (q < -128);
        r.yv = (q > 127) ? 127 : (q < -128) ? -128 : q;
        r.due = cyc + 3;
        pend.push_back(r);
      end
      phase = !phase;
    end
    exp_v = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      exp_v = 1; exp_y = 8'(r.yv); exp_d = (r.yv >= 0); exp_s = r.s;
      $display("txn cyc=%0d expect y=%0d d=%0b sat=%0b", cyc, r.yv, exp_d, exp_s);
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 1, 77, 0, pack_identity());
    tick(1, 1, 77, 0, pack_identity());
    total++; if (y !== 8'sd0) begin bad++; $display("FAIL reset_y got=%0d want=0", y); end
    total++; if (y_valid !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", y_valid); end
    total++; if (d !== 1'b0) begin bad++; $display("FAIL reset_d got=%b want=0", d); end
    total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b want=0", sat_flag); end
  endtask

  task automatic test_identity();
    tick(1, 0, 0, 0, pack_identity());
    for (int i = 0; i < 16; i++) begin
      tick(0, i < 12, 32, 0, pack_identity());
      total++; if (y_valid !== exp_v) begin bad++; $display("FAIL ident_vld cyc=%0d got=%b want=%b", cyc, y_valid, exp_v); end
      total++; if ({y, d, sat_flag} !== {exp_y, exp_d, exp_s}) begin bad++;
        $display("FAIL ident_out cyc=%0d got y=%0d d=%b s=%b want y=%0d d=%b s=%b", cyc, y, d, sat_flag, exp_y, exp_d, exp_s); end
    end
    total++; if ({y, d, sat_flag} !== {8'sd32, 1'b1, 1'b0}) begin bad++;
      $display("FAIL ident_final got y=%0d d=%b s=%b want y=32 d=1 s=0", y, d, sat_flag); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 26; i++) begin
      tick(0, (i % 13) < 10, (i < 13) ? 127 : -128, 0, pack_uniform(63));
      total++; if (y_valid !== exp_v) begin bad++; $display("FAIL sat_vld cyc=%0d got=%b want=%b", cyc, y_valid, exp_v); end
      total++; if ({y, d, sat_flag} !== {exp_y, exp_d, exp_s}) begin bad++;
        $display("FAIL sat_out cyc=%0d got y=%0d d=%b s=%b want y=%0d d=%b s=%b", cyc, y, d, sat_flag, exp_y, exp_d, exp_s); end
      if (i == 12) begin
        total++; if ({y, d, sat_flag} !== {8'sd127, 1'b1, 1'b1}) begin bad++;
          $display("FAIL sat_pos got y=%0d d=%b s=%b want y=127 d=1 s=1", y, d, sat_flag); end
      end
    end
    total++; if ({y, d, sat_flag} !== {-8'sd128, 1'b0, 1'b1}) begin bad++;
      $display("FAIL sat_neg got y=%0d d=%b s=%b want y=-128 d=0 s=1", y, d, sat_flag); end
  endtask

  task automatic test_cadence();
    int xs [20];
    logic signed [7:0] cont [$];
    logic signed [7:0] gap [$];
    logic [62:0] cf;
    for (int k = 0; k < NW; k++) cf[7*k +: 7] = 7'($urandom_range(40) - 20);
    for (int i = 0; i < 20; i++) xs[i] = int'($urandom_range(255)) - 128;
    for (int pass = 0; pass < 2; pass++) begin
      tick(1, 0, 0, 0, cf);
      for (int i = 0; i < 20 * (1 + 2 * pass) + 6; i++) begin
        if (pass == 0) tick(0, i < 20, (i < 20) ? xs[i] : 0, 0, cf);
        else           tick(0, (i % 3 == 0) && (i < 60), (i < 60) ? xs[i / 3] : 0, 0, cf);
        total++; if (y_valid !== exp_v) begin bad++; $display("FAIL cad_vld pass=%0d cyc=%0d got=%b want=%b", pass, cyc, y_valid, exp_v); end
        total++; if ({y, d, sat_flag} !== {exp_y, exp_d, exp_s}) begin bad++;
          $display("FAIL cad_out pass=%0d cyc=%0d got y=%0d want y=%0d", pass, cyc, y, exp_y); end
        if (y_valid) begin
          if (pass == 0) cont.push_back(y); else gap.push_back(y);
        end
      end
    end
    total++; if (gap.size() != 10 || cont.size() != 10) begin bad++;
      $display("FAIL cad_count got cont=%0d gap=%0d want 10/10", cont.size(), gap.size()); end
    for (int i = 0; i < 10 && i < gap.size() && i < cont.size(); i++) begin
      total++; if (gap[i] !== cont[i]) begin bad++; $display("FAIL cad_seq i=%0d got=%0d want=%0d", i, gap[i], cont[i]); end
    end
  endtask

  task automatic test_freeze();
    tick(1, 0, 0, 0, pack_identity());
    for (int i = 0; i < 40; i++) begin
      tick(0, 1, int'($urandom_range(255)) - 128, (i >= 8) && (i < 24),
           (i < 12) ? pack_identity() : '0);
      total++; if (y_valid !== exp_v) begin bad++; $display("FAIL frz_vld cyc=%0d got=%b want=%b", cyc, y_valid, exp_v); end
      total++; if ({y, d, sat_flag} !== {exp_y, exp_d, exp_s}) begin bad++;
        $display("FAIL frz_out cyc=%0d got y=%0d want y=%0d", cyc, y, exp_y); end
    end
    total++; if (y !== 8'sd0) begin bad++; $display("FAIL frz_final got y=%0d want 0", y); end
  endtask

  task automatic test_midreset();
    int pulses;
    pulses = 0;
    tick(1, 0, 0, 0, pack_identity());
    for (int i = 0; i < 10; i++) tick(0, 1, 50, 0, pack_identity());
    tick(0, 1, 50, 0, pack_identity());
    tick(0, 1, 50, 0, pack_identity());
    tick(1, 1, 50, 0, pack_identity());
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, pack_identity());
      if (y_valid) pulses++;
    end
    total++; if (pulses != 0 || y !== 8'sd0) begin bad++;
      $display("FAIL midrst_supp got pulses=%0d y=%0d want 0/0", pulses, y); end
    for (int i = 0; i < 6; i++) begin
      tick(0, i < 2, 50, 0, pack_identity());
      total++; if (y_valid !== exp_v) begin bad++; $display("FAIL midrst_vld cyc=%0d got=%b want=%b", cyc, y_valid, exp_v); end
      total++; if ({y, d, sat_flag} !== {exp_y, exp_d, exp_s}) begin bad++;
        $display("FAIL midrst_out cyc=%0d got y=%0d want y=%0d", cyc, y, exp_y); end
    end
  endtask

  task automatic test_random();
    logic [62:0] cf;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NW; k++) cf[7*k +: 7] = 7'($urandom_range(127));
      tick($urandom_range(99) < 2, $urandom_range(99) < 70, int'($urandom_range(255)) - 128,
           $urandom_range(99) < 30, cf);
      total++; if (y_valid !== exp_v) begin bad++; $display("FAIL rnd_vld cyc=%0d got=%b want=%b", cyc, y_valid, exp_v); end
      total++; if ({y, d, sat_flag} !== {exp_y, exp_d, exp_s}) begin bad++;
        $display("FAIL rnd_out cyc=%0d got y=%0d d=%b s=%b want y=%0d d=%b s=%b", cyc, y, d, sat_flag, exp_y, exp_d, exp_s); end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    reset = 1'b1; i_valid = 1'b0; freeze = 1'b0; x = '0; coeff = '0;
    test_reset();
    test_identity();
    test_saturation();
    test_cadence();
    test_freeze();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
